// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the handshake load/store unit (lsu_hs).
//   funct3_e  - RISC-V load/store width/sign codes (stores reuse LB/LH/LW as sb/sh/sw)
//   region_e  - decoded target of an access
//   state_e   - response FSM state
//   SLOT_*    - peripheral slot numbers inside region 0x4 (slot = addr[7:4])
//   byte_en / store_rep / merge_bytes / load_ext - byte-lane helpers
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {REG_DMEM, REG_OUT, REG_IN, REG_NONE} region_e;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  localparam logic [3:0] SLOT_LEDR  = 4'd8;
  localparam logic [3:0] SLOT_LEDG  = 4'd9;
  localparam logic [3:0] SLOT_LCD   = 4'd10;
  localparam logic [3:0] REGION_OUT = 4'h4;
  localparam logic [3:0] REGION_IN  = 4'h5;

  function automatic logic f3_legal(logic we, logic [2:0] f3);
    logic legal;
    case (f3)
      LB, LH, LW: legal = 1'b1;
      LBU, LHU:   legal = ~we;
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] f3, logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate LSB-aligned store data across lanes so the byte enable picks the right copy.
  function automatic logic [31:0] store_rep(logic [2:0] f3, logic [31:0] wdata);
    logic [31:0] rep;
    case (f3[1:0])
      2'b00:   rep = {4{wdata[7:0]}};
      2'b01:   rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

  function automatic logic [31:0] merge_bytes(logic [31:0] old, logic [31:0] wr, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wr & mask);
  endfunction

  function automatic logic [31:0] load_ext(logic [2:0] f3, logic [1:0] lane, logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {lane, 3'b000};
    case (f3)
      LB:      r = {{24{s[7]}}, s[7:0]};
      LBU:     r = {24'd0, s[7:0]};
      LH:      r = {{16{s[15]}}, s[15:0]};
      LHU:     r = {16'd0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_hs_if.sv
// lsu_hs_if: request/response handshake bundle between a core (master) and lsu_hs (slave).
//   req_*: valid/ready request with we, funct3, byte address and LSB-aligned store data
//   rsp_*: valid/ready response with extended load data and error flag
interface lsu_hs_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_dmem.sv
// lsu_dmem: single-port synchronous-read data RAM with per-byte write enable.
//   clk_i, en_i (access), we_i, be_i[3:0], addr_i (word index), wdata_i, rdata_o
// A read in the same cycle as a write to the same word returns the old contents.
// rdata_o only changes on an enabled access, so it holds while a response is stalled.
module lsu_dmem #(
  parameter int unsigned Words = 256,
  parameter int unsigned Aw    = $clog2(Words)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/lsu_hs.sv
// lsu_hs: load/store unit with valid/ready request and response channels.
//   clk_i, rst_i (async, active-high)
//   bus       - lsu_hs_if.slave request/response handshake
//   io_sw_i   - asynchronous switches, 2-flop synchronised, readable at 0x500
//   io_hex_o  - HEX registers at 0x400 + 0x10*k
//   io_ledr_o / io_ledg_o / io_lcd_o - registers at 0x480 / 0x490 / 0x4A0
// Each accepted request yields exactly one response in the following cycle.
// Optional: define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors;
// otherwise the low address bits are forced to natural alignment.
// Only addr[11:0] is decoded.
module lsu_hs
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned NUM_HEX    = 8,
  parameter int unsigned SW_W       = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  lsu_hs_if.slave                  bus,
  input  logic [SW_W-1:0]          io_sw_i,
  output logic [NUM_HEX-1:0][31:0] io_hex_o,
  output logic [31:0]              io_ledr_o,
  output logic [31:0]              io_ledg_o,
  output logic [31:0]              io_lcd_o
);
  localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

  state_e state_q, state_d;
  logic        accept, we, is_half, is_word, align_err, ok, out_wr;
  logic [2:0]  f3;
  logic [11:0] addr_raw, addr;
  logic [3:0]  slot, be;
  logic [7:0]  word_idx;
  logic [31:0] wrep, periph_rd, dmem_rdata;
  region_e     region;

  logic [NUM_HEX-1:0][31:0] hex_q;
  logic [31:0]     ledr_q, ledg_q, lcd_q;
  logic [SW_W-1:0] sw_meta_q, sw_sync_q;

  logic        rsp_err_q, rsp_load_q, rsp_dmem_q;
  logic [2:0]  rsp_f3_q;
  logic [1:0]  rsp_lane_q;
  logic [31:0] rsp_periph_q;

  assign addr_raw = bus.req_addr[11:0];
  assign f3       = bus.req_funct3;
  assign we       = bus.req_we;
  assign is_half  = (f3[1:0] == 2'b01);
  assign is_word  = (f3[1:0] == 2'b10);
  assign accept   = bus.req_valid & bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr      = addr_raw;
  assign align_err = (is_half & addr_raw[0]) | (is_word & (addr_raw[1:0] != 2'b00));
`else
  assign addr      = {addr_raw[11:2], addr_raw[1] & ~is_word, addr_raw[0] & ~is_half & ~is_word};
  assign align_err = 1'b0;
`endif

  assign slot     = addr[7:4];
  assign word_idx = addr[9:2];
  assign be       = byte_en(f3, addr[1:0]);
  assign wrep     = store_rep(f3, bus.req_wdata);

  // Address decode; only word 0 of each peripheral slot is mapped.
  always_comb begin
    region = REG_NONE;
    case (addr[11:8])
      4'h0, 4'h1, 4'h2, 4'h3: if (32'(word_idx) < DMEM_WORDS) region = REG_DMEM;
      REGION_OUT: begin
        if (addr[3:2] == 2'b00 && (32'(slot) < NUM_HEX || slot == SLOT_LEDR ||
            slot == SLOT_LEDG || slot == SLOT_LCD)) region = REG_OUT;
      end
      REGION_IN: if (addr[7:2] == 6'd0) region = REG_IN;
      default: ;
    endcase
  end

  assign ok     = f3_legal(we, f3) & ~align_err & (region != REG_NONE) &
                  ~(we & (region == REG_IN));
  assign out_wr = accept & we & ok & (region == REG_OUT);

  always_comb begin
    periph_rd = '0;
    if (region == REG_IN) begin
      periph_rd = 32'(sw_sync_q);
    end else begin
      for (int k = 0; k < NUM_HEX; k++) begin
        if (slot == 4'(k)) periph_rd = hex_q[k];
      end
      case (slot)
        SLOT_LEDR: periph_rd = ledr_q;
        SLOT_LEDG: periph_rd = ledg_q;
        SLOT_LCD:  periph_rd = lcd_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hex_q  <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
    end else if (out_wr) begin
      for (int k = 0; k < NUM_HEX; k++) begin
        if (slot == 4'(k)) hex_q[k] <= merge_bytes(hex_q[k], wrep, be);
      end
      if (slot == SLOT_LEDR) ledr_q <= merge_bytes(ledr_q, wrep, be);
      if (slot == SLOT_LEDG) ledg_q <= merge_bytes(ledg_q, wrep, be);
      if (slot == SLOT_LCD)  lcd_q  <= merge_bytes(lcd_q, wrep, be);
    end
  end

  assign io_hex_o  = hex_q;
  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_lcd_o  = lcd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= io_sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  // A store commits on its accept edge, so a load accepted on the next edge already
  // reads the new word; no forwarding path is needed around the RAM.
  lsu_dmem #(
    .Words (DMEM_WORDS),
    .Aw    (DmemAw)
  ) u_dmem (
    .clk_i   (clk_i),
    .en_i    (accept & ok & (region == REG_DMEM)),
    .we_i    (we),
    .be_i    (be),
    .addr_i  (word_idx[DmemAw-1:0]),
    .wdata_i (wrep),
    .rdata_o (dmem_rdata)
  );

  // Response context is captured only on accept so it holds while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_err_q    <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_dmem_q   <= 1'b0;
      rsp_f3_q     <= '0;
      rsp_lane_q   <= '0;
      rsp_periph_q <= '0;
    end else if (accept) begin
      rsp_err_q    <= ~ok;
      rsp_load_q   <= ~we & ok;
      rsp_dmem_q   <= (region == REG_DMEM);
      rsp_f3_q     <= f3;
      rsp_lane_q   <= addr[1:0];
      rsp_periph_q <= periph_rd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = accept ? S_RESP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE) | bus.rsp_ready;
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_err   = (state_q == S_RESP) & rsp_err_q;
    bus.rsp_rdata = '0;
    if (state_q == S_RESP && rsp_load_q) begin
      bus.rsp_rdata = load_ext(rsp_f3_q, rsp_lane_q, rsp_dmem_q ? dmem_rdata : rsp_periph_q);
    end
  end
endmodule

// File: tb/tb_lsu_hs.sv
module tb_lsu_hs;
  localparam int NWORDS = 256;
  localparam int NHEX   = 8;

  logic clk = 1'b0;
  logic rst;
  logic [17:0] sw;
  logic [NHEX-1:0][31:0] hex;
  logic [31:0] ledr, ledg, lcd;

  int checks = 0;
  int errors = 0;

  // Reference state: byte-addressed data memory, slot-indexed output registers, switches.
  logic [7:0]  m_dm [1024];
  logic [31:0] m_out [16];
  logic [31:0] m_sw;

  bit          exp_err_q [$];
  logic [31:0] exp_rd_q [$];

  lsu_hs_if #(.ADDR_W(12)) bus ();

  lsu_hs #(
    .ADDR_W     (12),
    .DMEM_WORDS (NWORDS),
    .NUM_HEX    (NHEX),
    .SW_W       (18)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .io_sw_i   (sw),
    .io_hex_o  (hex),
    .io_ledr_o (ledr),
    .io_ledg_o (ledg),
    .io_lcd_o  (lcd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit slot_mapped(int s);
    return (s < NHEX) || s == 8 || s == 9 || s == 10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_out[i] = '0;
  endtask

  // Reference behaviour from the address map and lane rules, byte by byte.
  task automatic model(input bit we, input logic [2:0] f3, input int addr_in,
                       input logic [31:0] wd, output bit e, output logic [31:0] rd);
    int size, a, lane, slot, kind, base;
    bit legal;
    logic [31:0] word;
    e = 0;
    rd = '0;
    slot = 0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    a = addr_in;
    if (legal && (a % size) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      e = 1;
`else
      a = a - (a % size);
`endif
    end
    kind = -1;
    if (a < 4 * NWORDS) kind = 0;
    else if (a >= 'h400 && a < 'h500 && (a % 16) < 4 && slot_mapped((a - 'h400) / 16)) begin
      kind = 1;
      slot = (a - 'h400) / 16;
    end else if (a >= 'h500 && a < 'h504) kind = 2;
    if (!legal || kind < 0 || (we && kind == 2)) e = 1;
    if (e) return;
    lane = a % 4;
    base = a - lane;
    if (kind == 0) word = {m_dm[base+3], m_dm[base+2], m_dm[base+1], m_dm[base]};
    else if (kind == 1) word = m_out[slot];
    else word = m_sw;
    if (we) begin
      for (int b = 0; b < size; b++) word[8*(lane+b) +: 8] = wd[8*b +: 8];
      if (kind == 0) for (int b = 0; b < 4; b++) m_dm[base+b] = word[8*b +: 8];
      else m_out[slot] = word;
    end else begin
      for (int b = 0; b < size; b++) rd[8*b +: 8] = word[8*(lane+b) +: 8];
      if (!f3[2] && size < 4 && rd[8*size-1])
        for (int b = size; b < 4; b++) rd[8*b +: 8] = 8'hFF;
    end
  endtask

  // One isolated request with rsp_ready high; returns the observed response.
  task automatic xact(input bit we, input logic [2:0] f3, input int addr, input logic [31:0] wd,
                      output logic e_o, output logic [31:0] rd_o);
    bit e;
    logic [31:0] rd;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = 12'(addr);
    bus.req_wdata  = wd;
    bus.rsp_ready  = 1'b1;
    #1;
    check("x_req_ready", bus.req_ready, 1'b1);
    model(we, f3, addr, wd, e, rd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("x_rsp_valid", bus.rsp_valid, 1'b1);
    check("x_rsp_err", bus.rsp_err, e);
    check("x_rsp_rdata", bus.rsp_rdata, rd);
    e_o  = bus.rsp_err;
    rd_o = bus.rsp_rdata;
  endtask

  initial begin
    logic e;
    logic [31:0] rd, exp_rd;
    bit me, took;
    bit          pw [5] = '{1, 0, 0, 0, 0};
    logic [2:0]  pf [5] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd1};
    int          pa [5] = '{'h020, 'h020, 'h010, 'h013, 'h402};

    rst = 1'b1;
    sw = '0;
    m_sw = '0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_hex", 32'(|hex), 32'd0);
    check("rst_ledr", ledr, 32'd0);
    check("rst_ledg", ledg, 32'd0);
    check("rst_lcd", lcd, 32'd0);
    rst = 1'b0;

    // Byte loads with sign/zero extension.
    xact(1, 3'd2, 'h010, 32'h12345678, e, rd);
    check("sw_rdata0", rd, 32'd0);
    check("sw_err0", e, 1'b0);
    xact(0, 3'd0, 'h013, 32'd0, e, rd);
    check("lb_13", rd, 32'h00000012);
    xact(0, 3'd4, 'h013, 32'd0, e, rd);
    check("lbu_13", rd, 32'h00000012);
    xact(1, 3'd2, 'h014, 32'h80, e, rd);
    xact(0, 3'd0, 'h014, 32'd0, e, rd);
    check("lb_14", rd, 32'hFFFFFF80);
    xact(0, 3'd4, 'h014, 32'd0, e, rd);
    check("lbu_14", rd, 32'h00000080);

    // Peripheral registers.
    xact(1, 3'd1, 'h402, 32'h0000BEEF, e, rd);
    check("hex0", hex[0], 32'hBEEF0000);
    xact(1, 3'd0, 'h480, 32'h0000003F, e, rd);
    check("ledr", ledr, 32'h0000003F);
    xact(0, 3'd2, 'h480, 32'd0, e, rd);
    check("lw_ledr", rd, 32'h0000003F);

    // Switches.
    sw = 18'h2ABCD;
    m_sw = 32'h0002ABCD;
    repeat (2) @(negedge clk);
    xact(0, 3'd2, 'h500, 32'd0, e, rd);
    check("lw_sw", rd, 32'h0002ABCD);
    xact(1, 3'd2, 'h500, 32'hFFFFFFFF, e, rd);
    check("sw_sw_err", e, 1'b1);
    xact(0, 3'd2, 'h500, 32'd0, e, rd);
    check("lw_sw_again", rd, 32'h0002ABCD);

    // Back-pressure: response held stable while rsp_ready is low.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr = 12'h010;
    bus.rsp_ready = 1'b0;
    #1;
    check("st_req_ready_idle", bus.req_ready, 1'b1);
    model(0, 3'd2, 'h010, 32'd0, me, exp_rd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("st_valid", bus.rsp_valid, 1'b1);
      check("st_rdata", bus.rsp_rdata, 32'h12345678);
      check("st_ready", bus.req_ready, 1'b0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("st_release_rdata", bus.rsp_rdata, exp_rd);
    check("st_release_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    #1;
    check("st_idle", bus.rsp_valid, 1'b0);

    // Back-to-back: store then four loads, one per cycle.
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) begin
        bus.req_valid = 1'b1;
        bus.req_we = pw[i];
        bus.req_funct3 = pf[i];
        bus.req_addr = 12'(pa[i]);
        bus.req_wdata = 32'h5A5AC3C3;
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        check("b2b_valid", bus.rsp_valid, 1'b1);
        check("b2b_err", bus.rsp_err, exp_err_q.pop_front());
        check("b2b_rdata", bus.rsp_rdata, exp_rd_q.pop_front());
      end
      if (i < 5) begin
        check("b2b_ready", bus.req_ready, 1'b1);
        model(pw[i], pf[i], pa[i], 32'h5A5AC3C3, me, exp_rd);
        exp_err_q.push_back(me);
        exp_rd_q.push_back(exp_rd);
      end
    end
    @(negedge clk);
    #1;
    check("b2b_done", bus.rsp_valid, 1'b0);

    // Error cases.
    xact(0, 3'd2, 'h602, 32'd0, e, rd);
    check("unmapped_err", e, 1'b1);
    check("unmapped_rdata", rd, 32'd0);
    xact(0, 3'd3, 'h010, 32'd0, e, rd);
    check("f3_011_err", e, 1'b1);
    xact(1, 3'd3, 'h480, 32'hFFFFFFFF, e, rd);
    check("f3_011_st_err", e, 1'b1);
    check("f3_011_ledr", ledr, 32'h0000003F);
    xact(1, 3'd2, 'h000, 32'hCAFEF00D, e, rd);
    xact(0, 3'd2, 'h002, 32'd0, e, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", e, 1'b1);
`else
    check("mis_data", rd, 32'hCAFEF00D);
`endif

    // Reset while a response is pending.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr = 12'h010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("mr_valid_before", bus.rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_valid_async", bus.rsp_valid, 1'b0);
    check("mr_hex", 32'(|hex), 32'd0);
    check("mr_ledr", ledr, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("mr_valid_release", bus.rsp_valid, 1'b0);
    check("mr_ready_release", bus.req_ready, 1'b1);
    @(negedge clk);
    #1;
    check("mr_no_stale", bus.rsp_valid, 1'b0);

    // Fill DMEM so random loads have defined data.
    for (int w = 0; w < NWORDS; w++) xact(1, 3'd2, 4 * w, $urandom, e, rd);

    // Random traffic with random back-pressure against the reference model.
    took = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int a;
      bit exp_ready;
      @(negedge clk);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.req_valid || took) begin
        if ($urandom_range(0, 4) != 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: a = $urandom_range(0, 1023);
            5, 6: a = 'h400 + 16 * $urandom_range(0, 15) + $urandom_range(0, 3) +
                      (($urandom_range(0, 5) == 0) ? 4 : 0);
            7: a = 'h500 + $urandom_range(0, 7);
            default: a = $urandom_range(0, 4095);
          endcase
          bus.req_valid = 1'b1;
          bus.req_we = 1'($urandom_range(0, 1));
          bus.req_funct3 = 3'($urandom_range(0, 7));
          bus.req_addr = 12'(a);
          bus.req_wdata = $urandom;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      #1;
      exp_ready = (exp_err_q.size() == 0) || bus.rsp_ready;
      check("rnd_valid", bus.rsp_valid, exp_err_q.size() != 0);
      check("rnd_ready", bus.req_ready, exp_ready);
      if (bus.rsp_ready && exp_err_q.size() != 0) begin
        check("rnd_err", bus.rsp_err, exp_err_q.pop_front());
        check("rnd_rdata", bus.rsp_rdata, exp_rd_q.pop_front());
      end
      took = bus.req_valid && exp_ready;
      if (took) begin
        model(bus.req_we, bus.req_funct3, int'(bus.req_addr), bus.req_wdata, me, exp_rd);
        exp_err_q.push_back(me);
        exp_rd_q.push_back(exp_rd);
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    if (exp_err_q.size() != 0) begin
      check("drain_err", bus.rsp_err, exp_err_q.pop_front());
      check("drain_rdata", bus.rsp_rdata, exp_rd_q.pop_front());
    end
    @(negedge clk);
    #1;
    check("drain_idle", bus.rsp_valid, 1'b0);

    for (int k = 0; k < NHEX; k++) check("end_hex", hex[k], m_out[k]);
    check("end_ledr", ledr, m_out[8]);
    check("end_ledg", ledg, m_out[9]);
    check("end_lcd", lcd, m_out[10]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
